// File: rtl/eth_f_hw_avmm_pkg.sv
// ---------------------------------------------------------------------------
// eth_f_hw_avmm_pkg
//   Shared Avalon-MM definitions for the HSSI host CSR read path.
//   - avmm_resp_t : 2-bit Avalon-MM response code carried on host_response.
// ---------------------------------------------------------------------------
package eth_f_hw_avmm_pkg;

  typedef enum logic [1:0] {
    AVMM_RESP_OKAY   = 2'b00,
    AVMM_RESP_RSVD   = 2'b01,
    AVMM_RESP_SLVERR = 2'b10,
    AVMM_RESP_DECERR = 2'b11
  } avmm_resp_t;

  // Width of the outstanding-read counter (must hold 0..max_pending).
  function automatic int pend_cnt_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage : eth_f_hw_avmm_pkg

// File: rtl/eth_f_hw_sat_counter.sv
// ---------------------------------------------------------------------------
// eth_f_hw_sat_counter
//   Saturating up-counter with synchronous clear (clear beats increment).
//   Ports:
//     clk    in   clock
//     arst_n in   async reset, active low
//     clr    in   synchronous clear
//     inc    in   increment request; ignored once count is all-ones
//     count  out  registered count value
// ---------------------------------------------------------------------------
module eth_f_hw_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear first, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = CNT_ZERO;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= CNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : eth_f_hw_sat_counter

// File: rtl/eth_f_hw_avmm_read_combine_pipe.sv
// ---------------------------------------------------------------------------
// eth_f_hw_avmm_read_combine_pipe
//   Merges read responses from NUM_CLIENTS Avalon-MM clients onto one host
//   read port. Up to MAX_PENDING reads may be outstanding; they retire in
//   order, one per cycle at most. A read with no answer for TIMEOUT_CYCLES
//   is completed with TIMEOUT_DATA / DECODEERROR. Simultaneous answers are
//   OR-combined and flagged SLAVEERROR. Answers with nothing outstanding are
//   dropped and counted.
//   Ports:
//     clk, arst_n                 clock, async active-low reset
//     host_read                   read request (accepted when !host_waitrequest)
//     host_waitrequest            high while MAX_PENDING reads are outstanding
//     host_readdata/_response     response data and code
//     host_readdata_valid         one-cycle response strobe
//     client_readdata_valid/data  per-client response strobe and data
//     stat_clear                  synchronous clear of the statistics
//     stat_*_cnt                  saturating timeout/collision/stray counters
//   Latency: client strobe -> host_readdata_valid is 2 clocks.
// ---------------------------------------------------------------------------
module eth_f_hw_avmm_read_combine_pipe
  import eth_f_hw_avmm_pkg::*;
#(
  parameter int                   DAT_WIDTH      = 32,
  parameter int                   NUM_CLIENTS    = 2,
  parameter int                   MAX_PENDING    = 4,
  parameter int                   TIMEOUT_CYCLES = 128,
  parameter logic [DAT_WIDTH-1:0] TIMEOUT_DATA   = 32'h12345678,
  parameter int                   STAT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             host_read,
  output logic                             host_waitrequest,
  output logic [DAT_WIDTH-1:0]             host_readdata,
  output logic [1:0]                       host_response,
  output logic                             host_readdata_valid,
  input  logic [NUM_CLIENTS-1:0]           client_readdata_valid,
  input  logic [NUM_CLIENTS*DAT_WIDTH-1:0] client_readdata,
  input  logic                             stat_clear,
  output logic [STAT_WIDTH-1:0]            stat_timeout_cnt,
  output logic [STAT_WIDTH-1:0]            stat_collision_cnt,
  output logic [STAT_WIDTH-1:0]            stat_stray_cnt
);

  localparam int PEND_W = pend_cnt_width(MAX_PENDING);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [PEND_W-1:0]      PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0]      PEND_ONE  = PEND_W'(1'b1);
  localparam logic [PEND_W-1:0]      PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [TMR_W-1:0]       TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]       TMR_ONE   = TMR_W'(1'b1);
  localparam logic [TMR_W-1:0]       TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [DAT_WIDTH-1:0]   DAT_ZERO  = {DAT_WIDTH{1'b0}};
  localparam logic [NUM_CLIENTS-1:0] VLD_ONE   = NUM_CLIENTS'(1'b1);
  localparam logic [NUM_CLIENTS-1:0] VLD_ZERO  = {NUM_CLIENTS{1'b0}};

  // Stage 1: registered client inputs.
  logic [NUM_CLIENTS-1:0]           valid_d, valid_q;
  logic [NUM_CLIENTS*DAT_WIDTH-1:0] data_d,  data_q;

  // Tracking state.
  logic [PEND_W-1:0] pending_d, pending_q;
  logic [TMR_W-1:0]  timer_d,   timer_q;
  logic              wait_d,    wait_q;

  // Stage 2: registered host outputs.
  logic                 host_valid_d, host_valid_q;
  logic [DAT_WIDTH-1:0] host_data_d,  host_data_q;
  avmm_resp_t           host_resp_d,  host_resp_q;

  // Decode of the registered responses.
  logic [DAT_WIDTH-1:0] comb_data;
  logic                 resp_any;
  logic                 resp_multi;
  logic                 has_pending;
  logic                 accept;
  logic                 retire_resp;
  logic                 retire_tmo;
  logic                 retire;
  logic                 stray;

  // Stage-1 next values are simply the client inputs.
  always_comb begin
    valid_d = client_readdata_valid;
    data_d  = client_readdata;
  end

  // OR together the data of every client strobing this cycle.
  always_comb begin
    comb_data = DAT_ZERO;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (valid_q[i]) begin
        comb_data = comb_data | data_q[i*DAT_WIDTH +: DAT_WIDTH];
      end else begin
        comb_data = comb_data;
      end
    end
  end

  // Retire/accept decisions. x & (x-1) is non-zero iff more than one bit is set.
  always_comb begin
    resp_any    = |valid_q;
    resp_multi  = |(valid_q & (valid_q - VLD_ONE));
    has_pending = (pending_q != PEND_ZERO);
    accept      = host_read & ~wait_q;
    retire_resp = resp_any & has_pending;
    // A response present at the threshold cycle takes precedence over the timeout.
    retire_tmo  = has_pending & ~resp_any & (timer_q == TMR_LAST);
    retire      = retire_resp | retire_tmo;
    stray       = resp_any & ~has_pending;
  end

  // Outstanding-read count, waitrequest and response timer.
  always_comb begin
    pending_d = pending_q;
    case ({accept, retire})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase
    // Registered so it follows pending with no extra cycle of lag.
    wait_d = (pending_d == PEND_MAX);
    // Timer measures how long the oldest read has waited; it never passes TMR_LAST
    // because reaching TMR_LAST always forces a retire.
    if (!has_pending || retire) begin
      timer_d = TMR_ZERO;
    end else begin
      timer_d = timer_q + TMR_ONE;
    end
  end

  // Host response formation.
  always_comb begin
    host_valid_d = retire;
    host_data_d  = DAT_ZERO;
    host_resp_d  = AVMM_RESP_OKAY;
    if (retire_resp) begin
      host_data_d = comb_data;
      host_resp_d = resp_multi ? AVMM_RESP_SLVERR : AVMM_RESP_OKAY;
    end else if (retire_tmo) begin
      host_data_d = TIMEOUT_DATA;
      host_resp_d = AVMM_RESP_DECERR;
    end else begin
      host_data_d = DAT_ZERO;
      host_resp_d = AVMM_RESP_OKAY;
    end
  end

  // All pipeline and tracking registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q      <= VLD_ZERO;
      data_q       <= {(NUM_CLIENTS*DAT_WIDTH){1'b0}};
      pending_q    <= PEND_ZERO;
      timer_q      <= TMR_ZERO;
      wait_q       <= 1'b0;
      host_valid_q <= 1'b0;
      host_data_q  <= DAT_ZERO;
      host_resp_q  <= AVMM_RESP_OKAY;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      pending_q    <= pending_d;
      timer_q      <= timer_d;
      wait_q       <= wait_d;
      host_valid_q <= host_valid_d;
      host_data_q  <= host_data_d;
      host_resp_q  <= host_resp_d;
    end
  end

  assign host_waitrequest    = wait_q;
  assign host_readdata_valid = host_valid_q;
  assign host_readdata       = host_data_q;
  assign host_response       = host_resp_q;

  eth_f_hw_sat_counter #(.WIDTH(STAT_WIDTH)) u_timeout_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (stat_clear),
    .inc    (retire_tmo),
    .count  (stat_timeout_cnt)
  );

  // Collisions are counted whether or not a read was outstanding.
  eth_f_hw_sat_counter #(.WIDTH(STAT_WIDTH)) u_collision_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (stat_clear),
    .inc    (resp_multi),
    .count  (stat_collision_cnt)
  );

  eth_f_hw_sat_counter #(.WIDTH(STAT_WIDTH)) u_stray_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (stat_clear),
    .inc    (stray),
    .count  (stat_stray_cnt)
  );

endmodule : eth_f_hw_avmm_read_combine_pipe
